// File: rtl/wb_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : wb_arbiter_if
//  Brief    : Bundle of the three internal master ports (fetcher, loader,
//             storer) plus the shared Wishbone bus port of wb_arbiter.
//             The "master" modport is the view of whatever drives the
//             requests and the bus responses; "slave" is the arbiter's view.
//  Revision : 1.0 - initial release
// ============================================================================
interface wb_arbiter_if;
    // Fetcher
    logic        i_f_cyc;
    logic [3:0]  i_f_stb;
    logic        i_f_we;
    logic [31:0] i_f_addr;
    logic        o_f_ack;
    logic        o_f_err;
    // Loader
    logic        i_l_cyc;
    logic [3:0]  i_l_stb;
    logic        i_l_we;
    logic [31:0] i_l_addr;
    logic        o_l_ack;
    logic        o_l_err;
    // Storer
    logic        i_s_cyc;
    logic [3:0]  i_s_stb;
    logic        i_s_we;
    logic [31:0] i_s_addr;
    logic [31:0] i_s_dat;
    logic        o_s_ack;
    logic        o_s_err;
    // Shared bus
    logic        o_wb_cyc;
    logic [3:0]  o_wb_stb;
    logic        o_wb_we;
    logic [31:0] o_wb_addr;
    logic [31:0] o_wb_dat;
    logic        i_wb_ack;
    logic        i_wb_err;
    logic        o_timeout;

    modport master (
        output i_f_cyc, i_f_stb, i_f_we, i_f_addr,
        output i_l_cyc, i_l_stb, i_l_we, i_l_addr,
        output i_s_cyc, i_s_stb, i_s_we, i_s_addr, i_s_dat,
        output i_wb_ack, i_wb_err,
        input  o_f_ack, o_f_err, o_l_ack, o_l_err, o_s_ack, o_s_err,
        input  o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_dat, o_timeout
    );

    modport slave (
        input  i_f_cyc, i_f_stb, i_f_we, i_f_addr,
        input  i_l_cyc, i_l_stb, i_l_we, i_l_addr,
        input  i_s_cyc, i_s_stb, i_s_we, i_s_addr, i_s_dat,
        input  i_wb_ack, i_wb_err,
        output o_f_ack, o_f_err, o_l_ack, o_l_err, o_s_ack, o_s_err,
        output o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_dat, o_timeout
    );
endinterface
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : wb_arbiter
//  Brief    : Registered-grant Wishbone arbiter sharing one bus port between
//             fetcher, loader and storer. Ownership lasts for the owner's
//             whole cyc; ack/err go to the owner only; a strobe left
//             unanswered for TIMEOUT cycles is aborted with err.
//             Define WB_ARB_RR_EN for round-robin arbitration; otherwise the
//             priority is fixed fetcher > loader > storer.
//  Revision : 1.0 - initial release
// ============================================================================
module wb_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic        i_clk,
    input  logic        i_reset,
    wb_arbiter_if.slave bus
);
    localparam logic [7:0] c_TIMEOUT = 8'(TIMEOUT);
    localparam bit         c_TO_EN   = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN_F = 2'd1,
        ST_OWN_L = 2'd2,
        ST_OWN_S = 2'd3
    } state_t;

    state_t      r_state;
    logic [7:0]  r_cnt;
`ifdef WB_ARB_RR_EN
    logic [1:0]  r_ptr;     // index of the last granted master (0=F,1=L,2=S)
`endif

    logic        w_own_f;
    logic        w_own_l;
    logic        w_own_s;
    logic        w_owner_cyc;
    logic [3:0]  w_owner_stb;
    logic        w_owner_we;
    logic [31:0] w_owner_addr;
    logic [3:0]  w_cand;
    logic        w_found;
    logic [1:0]  w_win;
    logic [1:0]  w_idx;
    logic        w_strobing;
    logic        w_fire;

    assign w_own_f = (r_state == ST_OWN_F);
    assign w_own_l = (r_state == ST_OWN_L);
    assign w_own_s = (r_state == ST_OWN_S);

`ifdef WB_ARB_RR_EN
    // k-th master in search order, starting just after the last grant.
    function automatic logic [1:0] rr_slot(input logic [1:0] ptr, input logic [1:0] k);
        logic [2:0] s;
        s = {1'b0, ptr} + {1'b0, k} + 3'd1;
        if (s >= 3'd3) begin
            s = s - 3'd3;
        end
        return s[1:0];
    endfunction
`endif

    // Select the current owner's signals; IDLE leaves the bus at zero.
    always_comb begin
        w_owner_cyc  = 1'b0;
        w_owner_stb  = 4'h0;
        w_owner_we   = 1'b0;
        w_owner_addr = 32'h0;
        case (r_state)
            ST_OWN_F: begin
                w_owner_cyc  = bus.i_f_cyc;
                w_owner_stb  = bus.i_f_stb;
                w_owner_we   = bus.i_f_we;
                w_owner_addr = bus.i_f_addr;
            end
            ST_OWN_L: begin
                w_owner_cyc  = bus.i_l_cyc;
                w_owner_stb  = bus.i_l_stb;
                w_owner_we   = bus.i_l_we;
                w_owner_addr = bus.i_l_addr;
            end
            ST_OWN_S: begin
                w_owner_cyc  = bus.i_s_cyc;
                w_owner_stb  = bus.i_s_stb;
                w_owner_we   = bus.i_s_we;
                w_owner_addr = bus.i_s_addr;
            end
            default: ;
        endcase
    end

    // The releasing owner is excluded so a handover never re-grants it.
    assign w_cand = {1'b0,
                     bus.i_s_cyc & ~w_own_s,
                     bus.i_l_cyc & ~w_own_l,
                     bus.i_f_cyc & ~w_own_f};

    // Pick the first requesting candidate in priority order.
    always_comb begin
        w_win   = 2'd0;
        w_found = 1'b0;
        w_idx   = 2'd0;
        for (int k = 0; k < 3; k++) begin
`ifdef WB_ARB_RR_EN
            w_idx = rr_slot(r_ptr, 2'(k));
`else
            w_idx = 2'(k);
`endif
            if (!w_found && w_cand[w_idx]) begin
                w_win   = w_idx;
                w_found = 1'b1;
            end
        end
    end

    assign w_strobing = w_owner_cyc & (|w_owner_stb);
    assign w_fire     = c_TO_EN && w_strobing && !bus.i_wb_ack && !bus.i_wb_err
                        && (r_cnt == c_TIMEOUT);

    // Grant register, round-robin pointer and strobe timeout counter.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= 8'd0;
`ifdef WB_ARB_RR_EN
            r_ptr   <= 2'd2;
`endif
        end else begin
            if (r_state == ST_IDLE || !w_owner_cyc) begin
                if (w_found) begin
                    case (w_win)
                        2'd0:    r_state <= ST_OWN_F;
                        2'd1:    r_state <= ST_OWN_L;
                        default: r_state <= ST_OWN_S;
                    endcase
`ifdef WB_ARB_RR_EN
                    r_ptr <= w_win;
`endif
                end else begin
                    r_state <= ST_IDLE;
                end
            end
            if (!w_strobing || bus.i_wb_ack || bus.i_wb_err || w_fire) begin
                r_cnt <= 8'd0;
            end else begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

    assign bus.o_wb_cyc  = w_owner_cyc;
    assign bus.o_wb_stb  = w_owner_cyc ? w_owner_stb : 4'h0;
    assign bus.o_wb_we   = w_owner_we;
    assign bus.o_wb_addr = w_owner_addr;
    assign bus.o_wb_dat  = w_own_s ? bus.i_s_dat : 32'h0;

    assign bus.o_f_ack   = bus.i_wb_ack & w_own_f;
    assign bus.o_l_ack   = bus.i_wb_ack & w_own_l;
    assign bus.o_s_ack   = bus.i_wb_ack & w_own_s;
    assign bus.o_f_err   = (bus.i_wb_err | w_fire) & w_own_f;
    assign bus.o_l_err   = (bus.i_wb_err | w_fire) & w_own_l;
    assign bus.o_s_err   = (bus.i_wb_err | w_fire) & w_own_s;
    assign bus.o_timeout = w_fire;
endmodule
`default_nettype wire
